// File: rtl/read_raw_guard.sv
// Read-after-write hazard guard: holds a read while it matches a pending write-queue entry.
// Optional statistics outputs are enabled with `define RAW_GUARD_STAT_EN.

`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

module read_raw_guard #(
    parameter int unsigned ADDR_WIDTH  = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS,
    parameter int unsigned SNOOP_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rd_valid,
    output logic                   o_rd_ready,
    input  logic [ADDR_WIDTH-1:0]  i_rd_addr,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_0,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_1,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_2,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_3,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_4,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_5,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_6,
    input  logic [ADDR_WIDTH:0]    i_wq_addr_7,
    output logic                   o_cmd_valid,
    input  logic                   i_cmd_ready,
    output logic [ADDR_WIDTH-1:0]  o_cmd_addr,
    output logic                   o_wr_drain_req,
    output logic [SNOOP_DEPTH-1:0] o_hit_vec
`ifdef RAW_GUARD_STAT_EN
    ,
    output logic [15:0]            o_hazard_cnt,
    output logic [7:0]             o_max_stall
`endif
);

    typedef enum logic [1:0] {StIdle, StCheck, StWait, StIssue} state_e;

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   held_addr;
    logic [ADDR_WIDTH:0]     snoop [SNOOP_DEPTH];
    logic [SNOOP_DEPTH-1:0]  hit;
    logic                    hit_any;

    // Valid bit gates the full-width address compare.
    always_comb begin
        snoop[0] = i_wq_addr_0;
        snoop[1] = i_wq_addr_1;
        snoop[2] = i_wq_addr_2;
        snoop[3] = i_wq_addr_3;
        snoop[4] = i_wq_addr_4;
        snoop[5] = i_wq_addr_5;
        snoop[6] = i_wq_addr_6;
        snoop[7] = i_wq_addr_7;
        hit = '0;
        for (int k = 0; k < SNOOP_DEPTH; k++) begin
            hit[k] = snoop[k][ADDR_WIDTH] && (snoop[k][ADDR_WIDTH-1:0] == held_addr);
        end
        hit_any = |hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= StIdle;
            o_rd_ready     <= 1'b0;
            o_cmd_valid    <= 1'b0;
            o_cmd_addr     <= '0;
            o_wr_drain_req <= 1'b0;
            o_hit_vec      <= '0;
            held_addr      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    o_rd_ready <= 1'b1;
                    if (i_rd_valid && o_rd_ready) begin
                        held_addr  <= i_rd_addr;
                        o_rd_ready <= 1'b0;
                        state      <= StCheck;
                    end
                end
                StCheck: begin
                    o_hit_vec <= hit;
                    if (hit_any) begin
                        o_wr_drain_req <= 1'b1;
                        state          <= StWait;
                    end else begin
                        o_cmd_valid <= 1'b1;
                        o_cmd_addr  <= held_addr;
                        state       <= StIssue;
                    end
                end
                StWait: begin
                    o_hit_vec <= hit;
                    if (!hit_any) begin
                        o_wr_drain_req <= 1'b0;
                        o_cmd_valid    <= 1'b1;
                        o_cmd_addr     <= held_addr;
                        state          <= StIssue;
                    end
                end
                StIssue: begin
                    // Committed: no hazard re-check here.
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        o_rd_ready  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef RAW_GUARD_STAT_EN
    logic [7:0] stall_q;
    logic [7:0] stall_inc;

    always_comb begin
        stall_inc = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hazard_cnt <= '0;
            o_max_stall  <= '0;
            stall_q      <= '0;
        end else begin
            if (state == StCheck && hit_any) begin
                stall_q <= '0;
                if (o_hazard_cnt != 16'hFFFF) begin
                    o_hazard_cnt <= o_hazard_cnt + 16'd1;
                end
            end else if (state == StWait) begin
                stall_q <= stall_inc;
                if (stall_inc > o_max_stall) begin
                    o_max_stall <= stall_inc;
                end
            end
        end
    end
`endif

endmodule
